// File: rtl/led_pattern_gen.sv
// Parametrised LED pattern generator: prescaled step/heartbeat ticks drive a
// shift/rotate/bounce/blink pattern on LEDG. Define LED_PATTERN_COUNT_MODE_EN to turn MODE=3 into an up-counter.
module led_pattern_gen #(
  parameter int LED_W     = 8,
  parameter int DIV_W     = 28,
  parameter int SLOW_BIT  = 26,
  parameter int BLINK_BIT = 27,
  parameter logic [LED_W-1:0] INIT_PAT = {{(LED_W-1){1'b0}}, 1'b1}
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [1:0]       MODE,
  input  logic             ENABLE,
  input  logic             LOAD,
  input  logic [LED_W-1:0] LOAD_VAL,
  output logic [LED_W:0]   LEDG,
  output logic             STEP
);

  typedef enum logic [1:0] {
    MODE_SHIFT_HB = 2'd0,
    MODE_ROTATE   = 2'd1,
    MODE_BOUNCE   = 2'd2,
    MODE_BLINK    = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam int M = LED_W - 1;
  localparam logic [LED_W-1:0] PAT_ONE = {{(LED_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt;
  logic             prev_slow, prev_blink;
  logic             heartbeat, hb_nxt;
  logic [LED_W-1:0] pattern, pat_nxt;
  dir_e             dir, dir_nxt;
  logic             step_nxt;
  logic             step_ev, hb_ev;

  assign step_ev = cnt[SLOW_BIT]  & ~prev_slow;
  assign hb_ev   = cnt[BLINK_BIT] & ~prev_blink;
  assign LEDG    = {pattern, heartbeat};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cnt        <= '0;
      prev_slow  <= 1'b0;
      prev_blink <= 1'b0;
      heartbeat  <= 1'b0;
      pattern    <= INIT_PAT;
      dir        <= DIR_LEFT;
      STEP       <= 1'b0;
    end else begin
      cnt        <= cnt + 1'b1;
      prev_slow  <= cnt[SLOW_BIT];
      prev_blink <= cnt[BLINK_BIT];
      heartbeat  <= hb_nxt;
      pattern    <= pat_nxt;
      dir        <= dir_nxt;
      STEP       <= step_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    pat_nxt  = pattern;
    dir_nxt  = dir;
    hb_nxt   = heartbeat;
    step_nxt = 1'b0;

    if (hb_ev && ENABLE) hb_nxt = ~heartbeat;

    if (LOAD) begin
      // Load overrides a coincident step; the step is simply lost.
      pat_nxt = LOAD_VAL;
      dir_nxt = DIR_LEFT;
    end else if (step_ev && ENABLE) begin
      step_nxt = 1'b1;
      case (mode_e'(MODE))
        MODE_SHIFT_HB: pat_nxt = {pattern[M-1:0], heartbeat};
        MODE_ROTATE: begin
          if (pattern == '0) pat_nxt = PAT_ONE;
          else               pat_nxt = {pattern[M-1:0], pattern[M]};
        end
        MODE_BOUNCE: begin
          if (pattern == '0) begin
            pat_nxt = PAT_ONE;
            dir_nxt = DIR_LEFT;
          end else if (dir == DIR_LEFT) begin
            if (pattern[M]) begin
              dir_nxt = DIR_RIGHT;
              pat_nxt = pattern >> 1;
            end else begin
              pat_nxt = pattern << 1;
            end
          end else begin
            if (pattern[0]) begin
              dir_nxt = DIR_LEFT;
              pat_nxt = pattern << 1;
            end else begin
              pat_nxt = pattern >> 1;
            end
          end
        end
        MODE_BLINK: begin
`ifdef LED_PATTERN_COUNT_MODE_EN
          pat_nxt = pattern + PAT_ONE;
`else
          pat_nxt = ~pattern;
`endif
        end
        default: pat_nxt = pattern;
      endcase
    end
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised LED pattern generator for DE2-class boards.
- Free-running prescaler produces a slow step tick and a slower heartbeat tick. LEDG[0] is the heartbeat blink; LEDG[LED_W:1] is a pattern register.
- The pattern advances per step in one of four modes: shift with heartbeat injection, rotate, bounce, or blink. Pattern is loadable.
- Sits directly on board LED pins; no downstream handshake.

Parameters:
- LED_W, 8, pattern width; LEDG width is LED_W+1. Minimum 2.
- DIV_W, 28, prescaler counter width.
- SLOW_BIT, 26, prescaler bit whose rising edge generates a pattern step. Must be < DIV_W.
- BLINK_BIT, 27, prescaler bit whose rising edge toggles the heartbeat. Must be < DIV_W.
- INIT_PAT, 1, reset value of the pattern register (LED_W bits).

Ports:
- CLOCK_50  in   1          system clock, all logic on rising edge.
- RESET     in   1          asynchronous, active-high reset.
- MODE      in   2          0 SHIFT_HB, 1 ROTATE, 2 BOUNCE, 3 BLINK.
- ENABLE    in   1          1 = steps and heartbeat toggles applied.
- LOAD      in   1          1 = load pattern from LOAD_VAL this cycle.
- LOAD_VAL  in   LED_W      pattern load value.
- LEDG      out  LED_W+1    [0] heartbeat, [LED_W:1] pattern.
- STEP      out  1          one-cycle pulse, registered, high the cycle after a step is applied.

Behaviour:
- Reset (async, immediate): cnt=0, prev_slow=0, prev_blink=0, heartbeat=0, pattern=INIT_PAT, dir=LEFT, STEP=0. With defaults, LEDG = 9'h002.
- Prescaler: cnt <= cnt+1 every cycle. Wraps modulo 2^DIV_W. Runs regardless of ENABLE.
- Edge detectors: prev_slow <= cnt[SLOW_BIT] and prev_blink <= cnt[BLINK_BIT] every cycle.
  - step_ev = cnt[SLOW_BIT] & ~prev_slow.
  - hb_ev = cnt[BLINK_BIT] & ~prev_blink.
- Timing:
  - First step_ev occurs when cnt == 2^SLOW_BIT. The pattern updates on that edge, i.e. clock edge 2^SLOW_BIT+1 after reset release.
  - Step period is 2^(SLOW_BIT+1) cycles; heartbeat half-period is 2^(BLINK_BIT+1) cycles.
- Heartbeat: if hb_ev & ENABLE, then heartbeat <= ~heartbeat.
- Pattern update priority, per cycle:
  1. LOAD=1: pattern <= LOAD_VAL, dir <= LEFT. Applies even when ENABLE=0; a coincident step is discarded and STEP stays 0.
  2. Otherwise, step_ev & ENABLE: apply MODE, then STEP pulses next cycle.
  3. Otherwise, hold.
- Modes (P = pattern, M = MSB index LED_W-1):
  - SHIFT_HB (0): P <= {P[M-1:0], heartbeat}. Uses the pre-toggle heartbeat value when hb_ev coincides.
  - ROTATE (1): P <= {P[M-1:0], P[M]}. If P==0, P <= 1.
  - BOUNCE (2): if P==0, P <= 1 and dir <= LEFT.
    - dir LEFT: if P[M], dir <= RIGHT and P <= P>>1; else P <= P<<1.
    - dir RIGHT: if P[0], dir <= LEFT and P <= P<<1; else P <= P>>1.
  - BLINK (3): P <= ~P.
- MODE is sampled only at step_ev. A mode change does not reset dir.
- ENABLE=0: LEDG frozen except for LOAD. No STEP pulses.
- Reset mid-operation: all state returns to reset values asynchronously. The prescaler restarts from 0.

Optional Feature:
- Macro LED_PATTERN_COUNT_MODE_EN.
- Defined: MODE=3 is a binary up-counter, P <= P+1 modulo 2^LED_W (0xFF → 0x00 at LED_W=8).
- Undefined: MODE=3 is BLINK as above. All other modes are identical either way.

Test Plan (LED_W=8, DIV_W=6, SLOW_BIT=2, BLINK_BIT=3, INIT_PAT=1; step every 8 cycles):
- Release RESET, MODE=0, ENABLE=1 -> pattern 0x02 at edge 5; LEDG[0]=1 at edge 9; pattern 0x05 at edge 13; STEP high cycle after each step.
- LOAD 0x81, MODE=1 -> subsequent steps give 0x03, 0x06, 0x0C; LOAD 0x00 then step -> 0x01.
- LOAD 0x40, MODE=2 -> steps give 0x80, 0x40 (reversed), 0x20; LOAD 0x02 and force dir RIGHT via reaching 0x80 first -> ... 0x02, 0x01, 0x02.
- LOAD 0xA5, MODE=3 (macro undefined) -> 0x5A, 0xA5; with LED_PATTERN_COUNT_MODE_EN, LOAD 0xFE -> 0xFF, 0x00, 0x01.
- ENABLE=0 for 3 step periods -> LEDG constant, STEP never high; LOAD 0x33 during that window -> pattern 0x33 next edge; LOAD coincident with step_ev -> load wins, no STEP.
- Assert RESET between clock edges mid-BOUNCE -> LEDG=9'h002 immediately without a clock edge; after release, first step again at edge 5.
